// File: rtl/iter_shifter.sv
// Iterative multi-cycle shifter: SLL, SRL, SRA and ROL by a variable amount,
// with valid/ready handshakes on both sides.
// Optional macro ITER_SHIFTER_FAST_EN: step 4 bits per cycle while at least
// 4 bits remain (results identical, lower latency).
module iter_shifter #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [1:0]         in_op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               busy
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StShift = 2'd1;
   localparam logic [1:0] StDone  = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic [1:0]         op_q, op_d;

   logic [WIDTH-1:0]   step_data;
   logic [SHAMT_W-1:0] step_cnt;

   // One-bit shift/rotate; op encoding 00 SLL, 01 SRL, 10 SRA, 11 ROL.
   function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] d,
                                              input logic [1:0] op);
      logic [WIDTH-1:0] r;
      case (op)
         2'b00:   r = {d[WIDTH-2:0], 1'b0};
         2'b01:   r = {1'b0, d[WIDTH-1:1]};
         2'b10:   r = {d[WIDTH-1], d[WIDTH-1:1]};
         default: r = {d[WIDTH-2:0], d[WIDTH-1]};
      endcase
      return r;
   endfunction

   // Data and count after one SHIFT-state step.
   always_comb begin
      step_data = step1(data_q, op_q);
      step_cnt  = cnt_q - SHAMT_W'(1);
`ifdef ITER_SHIFTER_FAST_EN
      // Zero-extended compare keeps the constant 4 representable when WIDTH=4.
      if ({1'b0, cnt_q} >= (SHAMT_W + 1)'(4)) begin
         step_data = step1(step1(step1(step1(data_q, op_q), op_q), op_q), op_q);
         step_cnt  = cnt_q - SHAMT_W'(4);
      end
`endif
   end

   // Next-state logic for the IDLE -> SHIFT -> DONE handshake sequence.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      case (state_q)
         StIdle: begin
            if (in_valid) begin
               data_d  = in_data;
               cnt_d   = in_shamt;
               op_d    = in_op;
               state_d = (in_shamt == '0) ? StDone : StShift;
            end
         end
         StShift: begin
            data_d = step_data;
            cnt_d  = step_cnt;
            if (step_cnt == '0) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers; asynchronous reset discards any in-flight request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         data_q  <= '0;
         cnt_q   <= '0;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
      end
   end

   // Handshake and status outputs decoded straight from the state.
   always_comb begin
      in_ready  = (state_q == StIdle);
      out_valid = (state_q == StDone);
      busy      = (state_q != StIdle);
      out_data  = data_q;
   end

endmodule
